// File: rtl/tone_contour_classifier.sv
// tone_contour_classifier
//   Captures NUM_FRAMES streamed FFT magnitude frames, keeps the peak bin of
//   each accepted frame, grades the change between consecutive peaks against
//   a percentage threshold, and classifies the overall pitch contour.
//
// Ports
//   clk_in, rst_in    clock, synchronous active-high reset
//   enable_in         arms capture; dropping it aborts a capture in progress
//   spacing_in        minimum idle cycles between accepted frames
//   fft_valid_in      spectrum beat valid
//   fft_last_in       last beat of a frame (qualified by fft_valid_in)
//   fft_data_in       unsigned bin magnitude
//   busy_out          high while capturing, calculating or reporting
//   frame_count_out   accepted frames in the current capture
//   step_codes_out    per-step codes, step k at [2k+1:2k]: 00 flat, 01 rise, 10 fall
//   tone_ident_out    1 level, 2 rising, 3 dipping, 4 falling, 7 unclassified
//   tone_valid_out    single-cycle result strobe
module tone_contour_classifier #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BIN_WIDTH  = 10,
  parameter int unsigned NUM_FRAMES = 4,
  parameter int unsigned THRESH_PCT = 20,
  parameter int unsigned MIN_BIN    = 1
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              enable_in,
  input  logic [31:0]                       spacing_in,
  input  logic                              fft_valid_in,
  input  logic                              fft_last_in,
  input  logic [DATA_WIDTH-1:0]             fft_data_in,
  output logic                              busy_out,
  output logic [$clog2(NUM_FRAMES+1)-1:0]   frame_count_out,
  output logic [2*(NUM_FRAMES-1)-1:0]       step_codes_out,
  output logic [2:0]                        tone_ident_out,
  output logic                              tone_valid_out
);

  localparam int unsigned FCW   = $clog2(NUM_FRAMES + 1);
  localparam int unsigned IW    = $clog2(NUM_FRAMES);
  localparam int unsigned NSTEP = NUM_FRAMES - 1;
  localparam int unsigned CW    = 2 * NSTEP;
  localparam int unsigned EW    = BIN_WIDTH + 8;

  localparam logic [EW-1:0]        HUNDRED     = EW'(100);
  localparam logic [EW-1:0]        RISE_MUL    = EW'(100 + THRESH_PCT);
  localparam logic [EW-1:0]        FALL_MUL    = EW'(100 - THRESH_PCT);
  localparam logic [BIN_WIDTH-1:0] MIN_BIN_IDX = BIN_WIDTH'(MIN_BIN);
  localparam logic [FCW-1:0]       LAST_FRAME  = FCW'(NUM_FRAMES - 1);
  localparam logic [IW-1:0]        LAST_STEP   = IW'(NUM_FRAMES - 2);

  localparam logic [1:0] CODE_FLAT = 2'b00;
  localparam logic [1:0] CODE_RISE = 2'b01;
  localparam logic [1:0] CODE_FALL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_CALC,
    S_REPORT
  } state_t;

  state_t                 state_q, state_d;
  logic [FCW-1:0]         frame_count_q, frame_count_d;
  logic [31:0]            gap_q, gap_d;
  logic                   in_frame_q, in_frame_d;
  logic                   accept_q, accept_d;
  logic [BIN_WIDTH-1:0]   bin_q, bin_d;
  logic [DATA_WIDTH-1:0]  peak_mag_q, peak_mag_d;
  logic [BIN_WIDTH-1:0]   peak_bin_q, peak_bin_d;
  logic [BIN_WIDTH-1:0]   frame_buf_q [NUM_FRAMES];
  logic [BIN_WIDTH-1:0]   frame_buf_d [NUM_FRAMES];
  logic [IW-1:0]          step_idx_q, step_idx_d;
  logic [CW-1:0]          codes_work_q, codes_work_d;
  logic [CW-1:0]          step_codes_q, step_codes_d;
  logic [2:0]             tone_ident_q, tone_ident_d;
  logic                   tone_valid_q, tone_valid_d;

  // Per-beat working values
  logic                   first_beat;
  logic                   frame_ok;
  logic [BIN_WIDTH-1:0]   beat_bin;
  logic [DATA_WIDTH-1:0]  base_mag;
  logic [BIN_WIDTH-1:0]   base_bin;
  logic [DATA_WIDTH-1:0]  nxt_mag;
  logic [BIN_WIDTH-1:0]   nxt_bin;
  logic [IW-1:0]          wr_idx;

  // Step grading values
  logic [IW-1:0]          nxt_step;
  logic [EW-1:0]          prev_ext;
  logic [EW-1:0]          cur_ext;
  logic [1:0]             step_code;

  // Classification values
  logic                   any_rise;
  logic                   any_fall;
  logic                   seen_change;
  logic                   first_is_fall;
  logic                   last_is_rise;
  logic [1:0]             cls_code;
  logic [2:0]             rpt_ident;

  assign wr_idx   = frame_count_q[IW-1:0];
  assign nxt_step = step_idx_q + IW'(1);

  // Percentage comparison without a divider: scale both sides by 100.
  always_comb begin
    prev_ext  = EW'(frame_buf_q[step_idx_q]);
    cur_ext   = EW'(frame_buf_q[nxt_step]);
    step_code = CODE_FLAT;
    if (cur_ext * HUNDRED > prev_ext * RISE_MUL) begin
      step_code = CODE_RISE;
    end else if (cur_ext * HUNDRED < prev_ext * FALL_MUL) begin
      step_code = CODE_FALL;
    end
  end

  // Contour classification over the completed step codes.
  always_comb begin
    any_rise      = 1'b0;
    any_fall      = 1'b0;
    seen_change   = 1'b0;
    first_is_fall = 1'b0;
    last_is_rise  = 1'b0;
    cls_code      = CODE_FLAT;
    for (int unsigned i = 0; i < NSTEP; i++) begin
      cls_code = codes_work_q[2*i +: 2];
      if (cls_code == CODE_RISE) begin
        any_rise     = 1'b1;
        last_is_rise = 1'b1;
        seen_change  = 1'b1;
      end else if (cls_code == CODE_FALL) begin
        any_fall     = 1'b1;
        last_is_rise = 1'b0;
        if (!seen_change) begin
          first_is_fall = 1'b1;
        end
        seen_change  = 1'b1;
      end
    end
    if (!any_rise && !any_fall) begin
      rpt_ident = 3'd1;
    end else if (any_rise && !any_fall) begin
      rpt_ident = 3'd2;
    end else if (any_fall && !any_rise) begin
      rpt_ident = 3'd4;
    end else if (first_is_fall && last_is_rise) begin
      rpt_ident = 3'd3;
    end else begin
      rpt_ident = 3'd7;
    end
  end

  // Peak candidate for the current beat; the first beat of a frame starts
  // from magnitude 0 at MIN_BIN so an all-zero frame reports MIN_BIN.
  always_comb begin
    first_beat = !in_frame_q;
    frame_ok   = first_beat ? (gap_q >= spacing_in) : accept_q;
    beat_bin   = first_beat ? '0 : bin_q;
    base_mag   = first_beat ? '0 : peak_mag_q;
    base_bin   = first_beat ? MIN_BIN_IDX : peak_bin_q;
    nxt_mag    = base_mag;
    nxt_bin    = base_bin;
    if ((beat_bin >= MIN_BIN_IDX) && (fft_data_in > base_mag)) begin
      nxt_mag = fft_data_in;
      nxt_bin = beat_bin;
    end
  end

  always_comb begin
    state_d       = state_q;
    frame_count_d = frame_count_q;
    gap_d         = (gap_q == '1) ? gap_q : gap_q + 32'd1;
    in_frame_d    = in_frame_q;
    accept_d      = accept_q;
    bin_d         = bin_q;
    peak_mag_d    = peak_mag_q;
    peak_bin_d    = peak_bin_q;
    frame_buf_d   = frame_buf_q;
    step_idx_d    = step_idx_q;
    codes_work_d  = codes_work_q;
    step_codes_d  = step_codes_q;
    tone_ident_d  = tone_ident_q;
    tone_valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_in) begin
          state_d       = S_CAPTURE;
          frame_count_d = '0;
          gap_d         = '1;
          in_frame_d    = 1'b0;
          accept_d      = 1'b0;
          bin_d         = '0;
          peak_mag_d    = '0;
          peak_bin_d    = MIN_BIN_IDX;
          codes_work_d  = '0;
        end
      end

      S_CAPTURE: begin
        if (!enable_in) begin
          state_d    = S_IDLE;
          in_frame_d = 1'b0;
        end else if (fft_valid_in) begin
          accept_d = frame_ok;
          if (frame_ok) begin
            peak_mag_d = nxt_mag;
            peak_bin_d = nxt_bin;
            bin_d      = beat_bin + BIN_WIDTH'(1);
          end
          if (fft_last_in) begin
            in_frame_d = 1'b0;
            if (frame_ok) begin
              frame_buf_d[wr_idx] = nxt_bin;
              frame_count_d       = frame_count_q + FCW'(1);
              gap_d               = '0;
              if (frame_count_q == LAST_FRAME) begin
                state_d    = S_CALC;
                step_idx_d = '0;
              end
            end
          end else begin
            in_frame_d = 1'b1;
          end
        end
      end

      S_CALC: begin
        // Unrolled so each step writes a constant slice of the code vector.
        for (int unsigned i = 0; i < NSTEP; i++) begin
          if (IW'(i) == step_idx_q) begin
            codes_work_d[2*i +: 2] = step_code;
          end
        end
        if (step_idx_q == LAST_STEP) begin
          state_d = S_REPORT;
        end else begin
          step_idx_d = nxt_step;
        end
      end

      S_REPORT: begin
        step_codes_d = codes_work_q;
        tone_ident_d = rpt_ident;
        tone_valid_d = 1'b1;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      frame_count_q <= '0;
      gap_q         <= '0;
      in_frame_q    <= 1'b0;
      accept_q      <= 1'b0;
      bin_q         <= '0;
      peak_mag_q    <= '0;
      peak_bin_q    <= '0;
      frame_buf_q   <= '{default: '0};
      step_idx_q    <= '0;
      codes_work_q  <= '0;
      step_codes_q  <= '0;
      tone_ident_q  <= '0;
      tone_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_count_q <= frame_count_d;
      gap_q         <= gap_d;
      in_frame_q    <= in_frame_d;
      accept_q      <= accept_d;
      bin_q         <= bin_d;
      peak_mag_q    <= peak_mag_d;
      peak_bin_q    <= peak_bin_d;
      frame_buf_q   <= frame_buf_d;
      step_idx_q    <= step_idx_d;
      codes_work_q  <= codes_work_d;
      step_codes_q  <= step_codes_d;
      tone_ident_q  <= tone_ident_d;
      tone_valid_q  <= tone_valid_d;
    end
  end

  assign busy_out        = (state_q != S_IDLE);
  assign frame_count_out = frame_count_q;
  assign step_codes_out  = step_codes_q;
  assign tone_ident_out  = tone_ident_q;
  assign tone_valid_out  = tone_valid_q;

endmodule

// File: tb/tb_tone_contour_classifier.sv
// Randomised scoreboard bench for tone_contour_classifier with a
// frame-level reference model (argmax per frame, percentage steps, contour).
module tb_tone_contour_classifier;

  localparam int unsigned NF   = 4;
  localparam int unsigned TH   = 20;
  localparam int unsigned MINB = 1;
  localparam int unsigned DW   = 32;
  localparam int unsigned BW   = 10;

  typedef logic [31:0] frame_t[$];

  typedef struct {
    logic [2:0] ident;
    logic [5:0] codes;
    int         cyc;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          enable_in;
  logic [31:0]   spacing_in;
  logic          fft_valid_in;
  logic          fft_last_in;
  logic [DW-1:0] fft_data_in;
  logic          busy_out;
  logic [2:0]    frame_count_out;
  logic [5:0]    step_codes_out;
  logic [2:0]    tone_ident_out;
  logic          tone_valid_out;

  tone_contour_classifier #(
    .DATA_WIDTH(DW),
    .BIN_WIDTH (BW),
    .NUM_FRAMES(NF),
    .THRESH_PCT(TH),
    .MIN_BIN   (MINB)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .enable_in      (enable_in),
    .spacing_in     (spacing_in),
    .fft_valid_in   (fft_valid_in),
    .fft_last_in    (fft_last_in),
    .fft_data_in    (fft_data_in),
    .busy_out       (busy_out),
    .frame_count_out(frame_count_out),
    .step_codes_out (step_codes_out),
    .tone_ident_out (tone_ident_out),
    .tone_valid_out (tone_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [2:0] last_ident = '0;
  logic [5:0] last_codes = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: lowest-index maximum at or above MINB, default MINB.
  function automatic int peak_of(input frame_t f);
    int          best = MINB;
    logic [31:0] best_mag = '0;
    for (int i = MINB; i < f.size(); i++) begin
      if (f[i] > best_mag) begin
        best_mag = f[i];
        best     = i;
      end
    end
    return best;
  endfunction

  task automatic model_push(input int pk[NF], input int last_c);
    exp_t       e;
    logic [5:0] codes = '0;
    byte        nz[$];
    int         nrise = 0;
    int         nfall = 0;
    for (int k = 0; k < NF - 1; k++) begin
      longint p = pk[k];
      longint c = pk[k+1];
      if (c * 100 > p * (100 + TH)) begin
        codes[2*k +: 2] = 2'b01;
        nz.push_back("r");
        nrise++;
      end else if (c * 100 < p * (100 - TH)) begin
        codes[2*k +: 2] = 2'b10;
        nz.push_back("f");
        nfall++;
      end
    end
    if (nz.size() == 0)                         e.ident = 3'd1;
    else if (nfall == 0)                        e.ident = 3'd2;
    else if (nrise == 0)                        e.ident = 3'd4;
    else if (nz[0] == "f" && nz[$] == "r")      e.ident = 3'd3;
    else                                        e.ident = 3'd7;
    e.codes = codes;
    e.cyc   = last_c + NF + 1;
    sb.push_back(e);
    last_ident = e.ident;
    last_codes = codes;
  endtask

  task automatic drive(input logic v, input logic l, input logic [31:0] d);
    @(posedge clk_in);
    #1;
    fft_valid_in = v;
    fft_last_in  = l;
    fft_data_in  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, $urandom);
  endtask

  function automatic frame_t make_frame(input int len, input int pk);
    frame_t f;
    for (int i = 0; i < len; i++) f.push_back((pk == 0) ? 32'd0 : 32'($urandom_range(0, 999)));
    if (pk != 0) begin
      f[pk] = 32'd5000 + 32'($urandom_range(0, 1000));
      if ($urandom_range(0, 2) == 0) f[0] = 32'd100000;
    end
    return f;
  endfunction

  // Leaves the last beat on the bus; the caller's next drive replaces it.
  task automatic send_frame(input frame_t f, input bit gappy, output int last_c);
    last_c = 0;
    for (int i = 0; i < f.size(); i++) begin
      if (gappy && $urandom_range(0, 3) == 0) idle(1);
      drive(1'b1, (i == f.size() - 1), f[i]);
      if (i == f.size() - 1) last_c = cyc;
    end
  endtask

  task automatic run_decision(input int len, input int peaks[NF], input bit gappy);
    int     got[NF];
    int     lc;
    frame_t fr;
    for (int f = 0; f < NF; f++) begin
      fr     = make_frame(len, peaks[f]);
      got[f] = peak_of(fr);
      send_frame(fr, gappy, lc);
    end
    model_push(got, lc);
    idle(8);
  endtask

  // Monitor: pops an expectation whenever the DUT strobes a result.
  initial begin
    exp_t e;
    logic prev_valid = 1'b0;
    forever begin
      @(negedge clk_in);
      if (prev_valid) chk("strobe_width", {31'd0, tone_valid_out}, 32'd0);
      if (tone_valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got strobe ident=%0d expected none (cycle %0d)", tone_ident_out, cyc);
        end else begin
          e = sb.pop_front();
          chk("tone_ident", {29'd0, tone_ident_out}, {29'd0, e.ident});
          chk("step_codes", {26'd0, step_codes_out}, {26'd0, e.codes});
          chk("strobe_cycle", cyc, e.cyc);
        end
      end
      prev_valid = (tone_valid_out === 1'b1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int     p[NF];
    int     got[NF];
    int     lc;
    int     a_pk;
    int     len;
    frame_t fr;

    rst_in       = 1'b1;
    enable_in    = 1'b0;
    spacing_in   = 32'd0;
    fft_valid_in = 1'b0;
    fft_last_in  = 1'b0;
    fft_data_in  = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_busy",   {31'd0, busy_out}, 32'd0);
    chk("rst_count",  {29'd0, frame_count_out}, 32'd0);
    chk("rst_codes",  {26'd0, step_codes_out}, 32'd0);
    chk("rst_ident",  {29'd0, tone_ident_out}, 32'd0);
    chk("rst_valid",  {31'd0, tone_valid_out}, 32'd0);
    @(posedge clk_in);
    #1;
    rst_in    = 1'b0;
    enable_in = 1'b1;
    idle(2);

    // Directed contours
    p = '{10, 10, 10, 10}; run_decision(64, p, 1'b0);
    p = '{10, 13, 16, 20}; run_decision(64, p, 1'b0);
    p = '{20, 15, 11, 16}; run_decision(64, p, 1'b0);
    p = '{10, 12, 12, 12}; run_decision(64, p, 1'b0);

    // Tie plus DC rejection: bin 0 largest, bins 5 and 9 tie -> peak 5
    for (int f = 0; f < NF; f++) begin
      fr.delete();
      for (int i = 0; i < 64; i++) fr.push_back(32'($urandom_range(0, 999)));
      if (f == 0) begin
        fr[0] = 32'd90000;
        fr[5] = 32'd7000;
        fr[9] = 32'd7000;
      end else begin
        fr[5] = 32'd6000;
      end
      got[f] = peak_of(fr);
      send_frame(fr, 1'b0, lc);
    end
    model_push(got, lc);
    idle(8);

    // Random decisions: varied lengths, stalls, all-zero frames
    for (int n = 0; n < 16; n++) begin
      len = $urandom_range(8, 64);
      for (int f = 0; f < NF; f++)
        p[f] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, len - 1));
      run_decision(len, p, 1'($urandom_range(0, 1)));
    end

    // Frame spacing: reject at 50 cycles, accept at 120
    spacing_in = 32'd100;
    fr = make_frame(64, 12); got[0] = peak_of(fr); send_frame(fr, 1'b0, lc);
    idle(49);
    fr = make_frame(64, 40); send_frame(fr, 1'b0, lc);
    idle(1);
    @(negedge clk_in);
    chk("spacing_reject", {29'd0, frame_count_out}, 32'd1);
    idle(5);
    fr = make_frame(64, 20); got[1] = peak_of(fr); send_frame(fr, 1'b0, lc);
    idle(1);
    @(negedge clk_in);
    chk("spacing_accept", {29'd0, frame_count_out}, 32'd2);
    idle(118);
    fr = make_frame(64, 30); got[2] = peak_of(fr); send_frame(fr, 1'b0, lc);
    idle(119);
    fr = make_frame(64, 8);  got[3] = peak_of(fr); send_frame(fr, 1'b0, lc);
    model_push(got, lc);
    idle(8);
    spacing_in = 32'd0;

    // Abort after two frames: no strobe, results held
    a_pk = $urandom_range(1, 63);
    fr = make_frame(64, a_pk); send_frame(fr, 1'b0, lc);
    idle(1);
    @(negedge clk_in);
    chk("capture_busy", {31'd0, busy_out}, 32'd1);
    chk("capture_count", {29'd0, frame_count_out}, 32'd1);
    fr = make_frame(64, 40); send_frame(fr, 1'b1, lc);
    idle(1);
    enable_in = 1'b0;
    idle(2);
    @(negedge clk_in);
    chk("abort_busy",  {31'd0, busy_out}, 32'd0);
    chk("abort_count", {29'd0, frame_count_out}, 32'd2);
    chk("abort_ident", {29'd0, tone_ident_out}, {29'd0, last_ident});
    chk("abort_codes", {26'd0, step_codes_out}, {26'd0, last_codes});
    idle(20);
    enable_in = 1'b1;
    idle(2);

    // Reset pulsed during CALC: everything clears, no strobe
    for (int f = 0; f < NF; f++) begin
      fr = make_frame(32, 4 + 6 * f);
      send_frame(fr, 1'b0, lc);
    end
    idle(1);
    rst_in = 1'b1;
    idle(1);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("calc_rst_busy",  {31'd0, busy_out}, 32'd0);
    chk("calc_rst_count", {29'd0, frame_count_out}, 32'd0);
    chk("calc_rst_codes", {26'd0, step_codes_out}, 32'd0);
    chk("calc_rst_ident", {29'd0, tone_ident_out}, 32'd0);
    chk("calc_rst_valid", {31'd0, tone_valid_out}, 32'd0);
    idle(10);

    // Recovery after reset
    p = '{30, 22, 22, 40}; run_decision(48, p, 1'b1);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk_in);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_contour_classifier.md
Name: tone_contour_classifier

Overview:
- Parametrised successor to the four-frame tone detector.
- Consumes a streamed FFT magnitude spectrum frame by frame and extracts the peak bin of each accepted frame.
- After NUM_FRAMES frames, compares consecutive peaks against a percentage threshold without a divider, then classifies the pitch contour (level / rising / dipping / falling / unclassified).
- Sits between the FFT output stream and the tone-identification consumer.

Parameters:
- DATA_WIDTH, 32, unsigned magnitude width of fft_data_in
- BIN_WIDTH, 10, bin index width; frames longer than 2^BIN_WIDTH beats are illegal
- NUM_FRAMES, 4, frames captured per decision, legal range 2..16
- THRESH_PCT, 20, significant-change threshold in percent, legal range 0..99
- MIN_BIN, 1, bins with index below this are ignored (DC rejection)

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- enable_in  in  1  arms capture; deassertion aborts the current capture
- spacing_in  in  32  minimum cycles from the last accepted fft_last to the next accepted frame start
- fft_valid_in  in  1  spectrum beat valid
- fft_last_in  in  1  last beat of frame; qualified by fft_valid_in
- fft_data_in  in  DATA_WIDTH  unsigned bin magnitude
- busy_out  out  1  high in CAPTURE, CALC and REPORT
- frame_count_out  out  $clog2(NUM_FRAMES+1)  accepted frames in the current capture
- step_codes_out  out  2*(NUM_FRAMES-1)  step k (frame k to k+1) at bits [2k+1:2k]; 00 flat, 01 rise, 10 fall
- tone_ident_out  out  3  1 level, 2 rising, 3 dipping, 4 falling, 7 unclassified, 0 none yet
- tone_valid_out  out  1  single-cycle result strobe

Behaviour:
- Reset: state IDLE; all outputs, counters, peak registers and frame buffer are 0.
- States: IDLE, CAPTURE, CALC, REPORT.
- IDLE → CAPTURE when enable_in=1.
  - On entry: frame_count and per-frame peak tracking cleared.
  - Gap counter preset to saturate, so the first frame is always accepted.
- CAPTURE, enable_in=0 in any cycle: return to IDLE; no result; outputs hold previous values.
- Gap counter:
  - 32-bit, saturating increment every cycle.
  - Cleared at the accepted frame's fft_last beat.
- Frame acceptance:
  - Decided on the first valid beat of a frame: accepted iff gap counter ≥ spacing_in.
  - A rejected frame is discarded until its fft_last beat; no counter or peak effect.
- Per accepted frame:
  - Bin index counts valid beats from 0.
  - Peak tracking initialises to magnitude 0, index MIN_BIN.
  - Peak updates only when bin ≥ MIN_BIN and magnitude is strictly greater, so ties keep the lower bin.
  - An all-zero frame reports MIN_BIN.
  - fft_last beat is included, then peak index is written to buffer[frame_count] and frame_count increments.
- CAPTURE → CALC on the cycle after the NUM_FRAMES-th accepted fft_last.
- CALC, one step per cycle (NUM_FRAMES-1 cycles):
  - prev = buffer[k], cur = buffer[k+1], unsigned width BIN_WIDTH+8.
  - Rise if cur*100 > prev*(100+THRESH_PCT).
  - Fall if cur*100 < prev*(100-THRESH_PCT).
  - Otherwise flat. Equality counts as flat.
- REPORT (1 cycle): classification over the step codes:
  - All flat → 1.
  - ≥1 rise and no fall → 2.
  - ≥1 fall and no rise → 4.
  - First non-flat step is fall and last non-flat step is rise → 3.
  - Anything else → 7.
- Outputs registered at the end of REPORT, then state returns to IDLE.
- Latency: tone_valid_out is high exactly NUM_FRAMES+1 cycles after the cycle presenting the final accepted fft_last beat.
- tone_ident_out and step_codes_out hold until the next report or reset.
- fft beats during CALC, REPORT and IDLE are ignored. Re-arming requires enable_in=1 in IDLE, so back-to-back decisions are allowed.
- A frame in progress when capture starts mid-frame: its remaining beats are treated as a new frame whose bin 0 is the first seen beat.
- rst_in mid-operation: immediate return to reset state; no strobe.

Test Plan:
- Parameters for all scenarios: NUM_FRAMES=4, THRESH_PCT=20, MIN_BIN=1, spacing_in=0, 64-beat frames.
- Peaks at bins 10,10,10,10 → step_codes=000000, tone_ident=1, strobe 5 cycles after the final last beat.
- Peaks 10,13,16,20 → codes 01/01/01 (1300>1200, 1600>1560, 2000>1920), tone_ident=2.
- Peaks 20,15,11,16 → fall, fall, rise (1600>1320), tone_ident=3.
- Peaks 10,12,12,12 → 1200 vs 1200 is flat, tone_ident=1.
- Peak ties plus DC rejection: bin 0 magnitude max, bins 5 and 9 tie → peak=5.
- spacing_in=100, second frame starting 50 cycles after the first's last → frame_count stays 1; a frame at 120 cycles is accepted.
- enable_in dropped after 2 frames → busy_out falls, no strobe, previous tone_ident held.
- rst_in pulsed during CALC → all outputs 0, no strobe.
